resample_sched: RTL and testbench
=================================

# resample_sched

Sequencer for the 160/147 polyphase resampling FIR. It owns the 4-phase handshakes to the upstream source and the downstream sink and tracks the polyphase phase accumulator. It drives the filter datapath with control signals: delay-line shift, tap select, coefficient address, and MAC clear/enable. It contains no sample arithmetic; it sits between the handshake ports and the MAC/delay-line datapath.

## Interface
- L, 160, interpolation factor (number of polyphase branches)
- M, 147, decimation factor; M < L required (at most one input per output)
- TAPS, 4, taps per polyphase branch
- L_LOG, 8, width of phase register (2^L_LOG >= L)
- TAP_LOG, 2, width of tap select (2^TAP_LOG >= TAPS)
- CA_LOG, 10, width of coefficient address (2^CA_LOG >= TAPS*L)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_in  out  1  request for next input sample (4-phase)
- ack_in  in  1  upstream acknowledge; data valid while high
- req_out  out  1  output sample ready in datapath accumulator (4-phase)
- ack_out  in  1  downstream acknowledge
- shift_en  out  1  one-cycle pulse: datapath shifts delay line and captures data_in into slot 0
- tap_sel  out  TAP_LOG  delay-line slot feeding the multiplier
- coef_addr  out  CA_LOG  coefficient ROM address = tap_sel*L + phase
- mac_clr  out  1  accumulator loads product instead of adding
- mac_en  out  1  accumulator update enable
- phase  out  L_LOG  current polyphase branch (n*M mod L for output n)
- frame_start  out  1  high during MAC of any output with phase 0

## Operation
- States: IDLE, REQ, REL, MAC, OUT, ORL. All outputs decode from registered state/counters only; there is no combinational input-to-output path.
- IDLE: outputs low. Goes to REQ next cycle unconditionally.
- REQ: req_in=1. Goes to REL when ack_in is sampled 1.
- REL: req_in=0. shift_en=1 in the first REL cycle only. Goes to MAC when ack_in is sampled 0. The source holds data_in while ack_in is high.
- MAC: exactly TAPS cycles. tap_cnt runs TAPS-1 down to 0, and tap_sel=tap_cnt. mac_en=1 throughout. mac_clr=1 only when tap_cnt=TAPS-1. Then goes to OUT.
- OUT: req_out=1. Goes to ORL when ack_out is sampled 1.
- ORL: req_out=0. When ack_out is sampled 0, the phase updates:
  - if phase+M >= L: phase <= phase+M-L, next state REQ (new input consumed);
  - else: phase <= phase+M, next state MAC (same delay-line contents, no input).
- Phase arithmetic uses L_LOG+1 bits internally; the result is always < L.
- coef_addr = tap_cnt*L + phase, computed at full CA_LOG width with no wrap. Its maximum is (TAPS-1)*L + L-1 = 639.
- Since gcd(M,L)=1, phase sequence period is L outputs, consuming exactly M inputs per period.
- ack_in outside REQ/REL, and ack_out outside OUT/ORL, are ignored.

## Timing
- Reset asserted (asynchronously, at any time including mid-MAC or mid-handshake):
  - state=IDLE, phase=0, tap_cnt=TAPS-1;
  - req_in, req_out, shift_en, mac_en, mac_clr, frame_start=0;
  - tap_sel=TAPS-1; coef_addr=(TAPS-1)*L.
- First edge after reset release: IDLE->REQ. req_in rises after that edge.
- Input handshake: minimum 2 cycles (REQ, REL), plus waits for ack_in.
- Output latency: the first req_out rises TAPS cycles after entering MAC.
- Per-output minimum: TAPS+2 cycles without shift, TAPS+4 with shift.
- req_in and req_out are never high simultaneously.
- mac_en is never high outside MAC. shift_en is never high outside REL.

## Test plan
- Reset, ack_in returned 1 cycle after req_in rises -> exactly one shift_en pulse, then 4 MAC cycles with tap_sel 3,2,1,0, coef_addr 480,320,160,0, mac_clr on the first cycle only, frame_start=1, then req_out=1.
- Run 160 outputs with immediate acks -> phases 0,147,134,121,… (output 159 has phase 13).
  - 148 input handshakes total (1 initial + 147).
  - Phase returns to 0 and frame_start repeats on output 160.
- Output 1 (phase 147 -> 147+147 ≥ 160) is followed by a shift; output 0 (0+147 < 160) is followed directly by MAC with no req_in.
- Hold ack_out low for 20 cycles in OUT -> req_out stays 1, and no mac_en or req_in occurs.
  - Hold ack_out high for 5 cycles in ORL -> no phase update until it drops.
- Assert rst during MAC cycle 2 -> all outputs go to their reset values immediately.
  - After release, the sequence restarts from phase 0 with a fresh input request.
- Spurious ack_in pulse during MAC and spurious ack_out during REQ -> no state change and no extra shift_en.

Source files
------------

// File: rtl/resample_sched.sv
// rtl/resample_sched.sv - control sequencer for the 160/147 polyphase resampling FIR
// Owns both 4-phase handshakes, the phase accumulator and the MAC/delay-line strobes.
module resample_sched #(
  parameter int L       = 160,
  parameter int M       = 147,
  parameter int TAPS    = 4,
  parameter int L_LOG   = 8,
  parameter int TAP_LOG = 2,
  parameter int CA_LOG  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               req_in,
  input  logic               ack_in,
  output logic               req_out,
  input  logic               ack_out,
  output logic               shift_en,
  output logic [TAP_LOG-1:0] tap_sel,
  output logic [CA_LOG-1:0]  coef_addr,
  output logic               mac_clr,
  output logic               mac_en,
  output logic [L_LOG-1:0]   phase,
  output logic               frame_start
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_MAC, S_OUT, S_ORL} state_e;

  localparam logic [L_LOG:0]     M_W      = (L_LOG+1)'(M);
  localparam logic [L_LOG:0]     L_W      = (L_LOG+1)'(L);
  localparam logic [TAP_LOG-1:0] TAP_TOP  = TAP_LOG'(TAPS-1);
  localparam logic [TAP_LOG-1:0] TAP_ONE  = TAP_LOG'(1);
  localparam logic [CA_LOG-1:0]  L_CA     = CA_LOG'(L);
  localparam logic [CA_LOG-1:0]  RST_COEF = CA_LOG'((TAPS-1)*L);

  state_e             state_q, state_d;
  logic [TAP_LOG-1:0] tap_q, tap_d;
  logic [L_LOG-1:0]   phase_q, phase_d;
  logic [L_LOG:0]     phase_sum;
  logic [CA_LOG-1:0]  coef_q, coef_d;
  logic               req_in_q, req_out_q, shift_en_q;
  logic               mac_en_q, mac_clr_q, frame_start_q;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    phase_d   = phase_q;
    phase_sum = {1'b0, phase_q} + M_W;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (ack_in) state_d = S_REL;
      S_REL: begin
        if (!ack_in) begin
          state_d = S_MAC;
          tap_d   = TAP_TOP;
        end
      end
      S_MAC: begin
        if (tap_q == '0) begin
          state_d = S_OUT;
          tap_d   = TAP_TOP;
        end else begin
          tap_d = tap_q - TAP_ONE;
        end
      end
      S_OUT: if (ack_out) state_d = S_ORL;
      S_ORL: begin
        // A wrap past L means the next branch needs one more input sample.
        if (!ack_out) begin
          if (phase_sum >= L_W) begin
            phase_d = L_LOG'(phase_sum - L_W);
            state_d = S_REQ;
          end else begin
            phase_d = phase_sum[L_LOG-1:0];
            state_d = S_MAC;
            tap_d   = TAP_TOP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    coef_d = CA_LOG'(tap_d) * L_CA + CA_LOG'(phase_d);
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      tap_q         <= TAP_TOP;
      phase_q       <= '0;
      coef_q        <= RST_COEF;
      req_in_q      <= 1'b0;
      req_out_q     <= 1'b0;
      shift_en_q    <= 1'b0;
      mac_en_q      <= 1'b0;
      mac_clr_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      phase_q       <= phase_d;
      coef_q        <= coef_d;
      req_in_q      <= (state_d == S_REQ);
      req_out_q     <= (state_d == S_OUT);
      shift_en_q    <= (state_d == S_REL) && (state_q != S_REL);
      mac_en_q      <= (state_d == S_MAC);
      mac_clr_q     <= (state_d == S_MAC) && (tap_d == TAP_TOP);
      frame_start_q <= (state_d == S_MAC) && (phase_d == '0);
    end
  end

  assign req_in      = req_in_q;
  assign req_out     = req_out_q;
  assign shift_en    = shift_en_q;
  assign tap_sel     = tap_q;
  assign coef_addr   = coef_q;
  assign mac_clr     = mac_clr_q;
  assign mac_en      = mac_en_q;
  assign phase       = phase_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_resample_sched.sv
// tb/tb_resample_sched.sv - self-checking bench for resample_sched
// Directed vector table, free-running handshake responders and an output-indexed reference model.
module tb_resample_sched;

  localparam int L = 160, M = 147, TAPS = 4, L_LOG = 8, TAP_LOG = 2, CA_LOG = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack_in = 1'b0, ack_out = 1'b0;
  logic req_in, req_out, shift_en, mac_clr, mac_en, frame_start;
  logic [TAP_LOG-1:0] tap_sel;
  logic [CA_LOG-1:0]  coef_addr;
  logic [L_LOG-1:0]   phase;

  int n_checks = 0, n_fail = 0;
  bit auto_in = 1'b0, auto_out = 1'b0;
  int max_dly = 0;
  int out_idx = 0, mac_cyc = 0, shifts = 0;
  bit prev_shift = 1'b0;
  int burst_phase [0:511];
  int shifts_at   [0:511];

  typedef struct {
    logic       ai;
    logic       ao;
    logic [5:0] flags;
    int         tap;
    int         coef;
    int         ph;
  } vec_t;
  vec_t vec [10];

  resample_sched #(.L(L), .M(M), .TAPS(TAPS), .L_LOG(L_LOG), .TAP_LOG(TAP_LOG), .CA_LOG(CA_LOG)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .req_out(req_out), .ack_out(ack_out),
    .shift_en(shift_en), .tap_sel(tap_sel), .coef_addr(coef_addr), .mac_clr(mac_clr),
    .mac_en(mac_en), .phase(phase), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_flags"}, {req_in, req_out, shift_en, mac_en, mac_clr, frame_start}, 0);
    chk({nm, "_tap"}, tap_sel, TAPS-1);
    chk({nm, "_coef"}, coef_addr, (TAPS-1)*L);
    chk({nm, "_phase"}, phase, 0);
  endtask

  task automatic wait_for(input int sel, input string nm);
    bit hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      case (sel)
        0:       hit = req_out;
        1:       hit = mac_en & mac_clr;
        default: hit = req_in;
      endcase
    end
    chk(nm, hit, 1);
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k = 0;
    while (out_idx < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_outputs", int'(out_idx >= n), 1);
  endtask

  // Reference model: output n uses branch n*M mod L and needs floor(n*M/L)+1 inputs.
  always @(negedge clk) begin
    int exp_ph;
    if (!rst) begin
      out_idx = 0; mac_cyc = 0; shifts = 0; prev_shift = 1'b0;
    end else begin
      chk("req_overlap", int'(req_in & req_out), 0);
      chk("shift_excl", int'(shift_en & (req_in | req_out | mac_en | prev_shift)), 0);
      if (shift_en) shifts++;
      prev_shift = shift_en;
      if (mac_en) begin
        exp_ph = (out_idx * M) % L;
        if (mac_cyc == 0 && out_idx < 512) begin
          burst_phase[out_idx] = int'(phase);
          shifts_at[out_idx]   = shifts;
          chk("shift_count", shifts, (out_idx * M) / L + 1);
        end
        chk("tap_sel", tap_sel, TAPS-1-mac_cyc);
        chk("coef_addr", coef_addr, (TAPS-1-mac_cyc)*L + exp_ph);
        chk("phase", phase, exp_ph);
        chk("mac_clr", mac_clr, mac_cyc == 0);
        chk("frame_start", frame_start, exp_ph == 0);
        mac_cyc++;
      end else if (mac_cyc != 0) begin
        chk("burst_len", mac_cyc, TAPS);
        chk("req_out_after_mac", req_out, 1);
        mac_cyc = 0;
        out_idx++;
      end else begin
        chk("idle_strobes", int'(mac_clr | frame_start), 0);
      end
    end
  end

  initial begin
    int viol, s0;
    logic [L_LOG-1:0] ph0;

    vec[0] = '{1'b0, 1'b0, 6'b000000, 3, 480, 0};
    vec[1] = '{1'b1, 1'b0, 6'b100000, 3, 480, 0};
    vec[2] = '{1'b0, 1'b0, 6'b001000, 3, 480, 0};
    vec[3] = '{1'b0, 1'b0, 6'b000111, 3, 480, 0};
    vec[4] = '{1'b0, 1'b0, 6'b000101, 2, 320, 0};
    vec[5] = '{1'b0, 1'b0, 6'b000101, 1, 160, 0};
    vec[6] = '{1'b0, 1'b0, 6'b000101, 0, 0, 0};
    vec[7] = '{1'b0, 1'b1, 6'b010000, 3, 480, 0};
    vec[8] = '{1'b0, 1'b0, 6'b000000, 3, 480, 0};
    vec[9] = '{1'b0, 1'b0, 6'b000110, 3, 627, 147};

    fork
      begin
        int ci = 0, co = 0;
        forever begin
          @(negedge clk);
          if (auto_in && (req_in != ack_in)) begin
            if (ci == 0) begin
              ack_in = req_in;
              ci = $urandom_range(0, max_dly);
            end else ci--;
          end
          if (auto_out && (req_out != ack_out)) begin
            if (co == 0) begin
              ack_out = req_out;
              co = $urandom_range(0, max_dly);
            end else co--;
          end
        end
      end
    join_none

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_flags", i), {req_in, req_out, shift_en, mac_en, mac_clr, frame_start}, vec[i].flags);
      chk($sformatf("vec%0d_tap", i), tap_sel, vec[i].tap);
      chk($sformatf("vec%0d_coef", i), coef_addr, vec[i].coef);
      chk($sformatf("vec%0d_phase", i), phase, vec[i].ph);
      ack_in  = vec[i].ai;
      ack_out = vec[i].ao;
      @(negedge clk);
    end

    max_dly = 0; auto_in = 1'b1; auto_out = 1'b1;
    wait_outputs(161, 3000);
    chk("ph_out1", burst_phase[1], 147);
    chk("ph_out2", burst_phase[2], 134);
    chk("ph_out159", burst_phase[159], 13);
    chk("ph_out160", burst_phase[160], 0);
    chk("shifts_out1", shifts_at[1], 1);
    chk("shifts_out2", shifts_at[2], 2);
    chk("shifts_out160", shifts_at[160], 148);

    auto_in = 1'b0; auto_out = 1'b0;
    @(negedge clk);
    rst = 1'b0; ack_in = 1'b0; ack_out = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    max_dly = 5; auto_in = 1'b1; auto_out = 1'b1;
    wait_outputs(200, 12000);

    wait_for(1, "hold_mac_seen");
    auto_out = 1'b0;
    wait_for(0, "hold_req_out_seen");
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (!req_out || mac_en || req_in) viol++;
    end
    chk("hold_out_stall", viol, 0);
    ph0 = phase;
    ack_out = 1'b1;
    @(negedge clk);
    chk("orl_entered", req_out, 0);
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (phase != ph0 || mac_en || req_in || req_out) viol++;
    end
    chk("orl_hold", viol, 0);
    ack_out = 1'b0;
    @(negedge clk);
    chk("phase_update", phase, (int'(ph0) + M) % L);
    auto_out = 1'b1;

    wait_for(1, "spur_mac_seen");
    auto_in = 1'b0;
    s0 = shifts;
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    wait_for(2, "spur_req_seen");
    chk("spur_in_shift", shifts, s0);
    auto_out = 1'b0;
    ack_out = 1'b1;
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (!req_in || req_out || mac_en || shift_en) viol++;
    end
    chk("spur_out_stall", viol, 0);
    ack_out = 1'b0;
    @(negedge clk);
    chk("spur_out_shift", shifts, s0);
    auto_in = 1'b1; auto_out = 1'b1;
    wait_outputs(out_idx + 3, 500);

    wait_for(1, "rst_mac_seen");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset("midmac_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_outputs(3, 500);
    chk("restart_ph0", burst_phase[0], 0);
    chk("restart_shift0", shifts_at[0], 1);
    chk("restart_ph1", burst_phase[1], 147);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
